// File: rtl/fpu_pkg.sv
// Shared types and constants for the binary32 add/subtract unit.
package fpu_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } float32;

  localparam int unsigned EXP_BIAS = 127;
  localparam logic [7:0]  EXP_MAX  = 8'hff;
  localparam logic [31:0] QNAN     = 32'h7fffffff;
  localparam logic [31:0] POS_INF  = 32'h7f800000;
  localparam int unsigned RM_TTE   = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND
  } state_t;

  // Leading-zero count of a 27-bit mantissa; the highest set bit wins.
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int unsigned i = 0; i < 27; i++) begin
      if (v[i]) n = 5'(26 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/fpu_operands.sv
// Splits two binary32 operands into fields and classifies them for alignment.
module fpu_operands
  import fpu_pkg::*;
(
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic        x_sign,
  output logic [7:0]  x_exp,
  output logic [22:0] x_frac,
  output logic        y_sign,
  output logic [7:0]  y_exp,
  output logic [22:0] y_frac,
  output logic        x_greater,
  output logic [7:0]  exp_shift,
  output logic        x_inf,
  output logic        y_inf,
  output logic        x_nan,
  output logic        y_nan
);

  float32 xf;
  float32 yf;

  always_comb begin
    xf        = float32'(x);
    yf        = float32'(y);
    x_sign    = xf.sign;
    x_exp     = xf.exp;
    x_frac    = xf.frac;
    y_sign    = yf.sign;
    y_exp     = yf.exp;
    y_frac    = yf.frac;
    x_greater = {xf.exp, xf.frac} >= {yf.exp, yf.frac};
    exp_shift = x_greater ? (xf.exp - yf.exp) : (yf.exp - xf.exp);
    x_inf     = (xf.exp == EXP_MAX) && (xf.frac == '0);
    y_inf     = (yf.exp == EXP_MAX) && (yf.frac == '0);
    x_nan     = (xf.exp == EXP_MAX) && (xf.frac != '0);
    y_nan     = (yf.exp == EXP_MAX) && (yf.frac != '0);
  end

endmodule

// File: rtl/fpu_adder.sv
// Multi-cycle binary32 adder: IDLE -> ALIGN -> ADD -> NORM -> ROUND, result pulsed out.
module fpu_adder
  import fpu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_ready_i,
  input  logic [6:0]  rounding_mode_i,
  input  logic [31:0] x_i,
  input  logic [31:0] y_i,
  output logic        data_valid_o,
  output logic [31:0] z_o,
  output logic        except_invalid_operation_o,
  output logic        except_overflow_o
);

  localparam logic [9:0] EXP_OVF = 10'(2 * EXP_BIAS + 1);

  state_t      state;
  logic [31:0] x_q, y_q;
  logic        rne_q;

  logic        x_sign, y_sign, x_greater, x_inf, y_inf, x_nan, y_nan;
  logic [7:0]  x_exp, y_exp, exp_shift;
  logic [22:0] x_frac, y_frac;

  logic        sign_r, sub_r, special_r, special_inv_r, zero_r;
  logic [31:0] special_z_r;
  logic [9:0]  exp_r;
  logic [23:0] big_sig_r;
  logic [26:0] small_al_r;
  logic [27:0] sum_r;
  logic [26:0] mant_r;

  fpu_operands u_operands (
    .x         (x_q),
    .y         (y_q),
    .x_sign    (x_sign),
    .x_exp     (x_exp),
    .x_frac    (x_frac),
    .y_sign    (y_sign),
    .y_exp     (y_exp),
    .y_frac    (y_frac),
    .x_greater (x_greater),
    .exp_shift (exp_shift),
    .x_inf     (x_inf),
    .y_inf     (y_inf),
    .x_nan     (x_nan),
    .y_nan     (y_nan)
  );

  logic [23:0] small_sig;
  logic [49:0] small_ext;
  logic [26:0] small_al;
  logic        spec, spec_inv;
  logic [31:0] spec_z;

  // Smaller significand lands as {24-bit sig, guard, round, sticky}.
  always_comb begin
    small_sig = {1'b1, x_greater ? y_frac : x_frac};
    small_ext = {small_sig, 26'd0} >> exp_shift;
    small_al  = (exp_shift >= 8'd26) ? 27'd1 : {small_ext[49:24], |small_ext[23:0]};
    spec      = 1'b1;
    spec_inv  = 1'b0;
    spec_z    = '0;
    if (x_nan || y_nan || (x_inf && y_inf)) begin
      spec_z   = QNAN;
      spec_inv = 1'b1;
    end else if (x_inf) spec_z = x_q;
    else if (y_inf) spec_z = y_q;
    else if ((x_exp == '0) && (y_exp == '0)) spec_z = '0;
    else if (x_exp == '0) spec_z = y_q;
    else if (y_exp == '0) spec_z = x_q;
    else spec = 1'b0;
  end

  logic [4:0]  lz;
  logic [26:0] norm_mant;
  logic        round_up;
  logic [24:0] rsig;
  logic [9:0]  fin_exp;
  logic [22:0] fin_frac;
  logic        unused_bits;

  always_comb begin
    lz          = lzc27(sum_r[26:0]);
    norm_mant   = sum_r[26:0] << lz;
    round_up    = rne_q & mant_r[2] & (mant_r[1] | mant_r[0] | mant_r[3]);
    rsig        = {1'b0, mant_r[26:3]} + 25'(round_up);
    fin_exp     = exp_r + 10'(rsig[24]);
    fin_frac    = rsig[24] ? '0 : rsig[22:0];
    unused_bits = rsig[23] ^ (^rounding_mode_i[6:1]);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state                      <= S_IDLE;
      z_o                        <= '0;
      data_valid_o               <= 1'b0;
      except_invalid_operation_o <= 1'b0;
      except_overflow_o          <= 1'b0;
    end else begin
      data_valid_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (data_ready_i) begin
            x_q   <= x_i;
            y_q   <= y_i;
            rne_q <= rounding_mode_i[RM_TTE];
            state <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          sign_r        <= x_greater ? x_sign : y_sign;
          sub_r         <= x_sign ^ y_sign;
          exp_r         <= 10'(x_greater ? x_exp : y_exp);
          big_sig_r     <= {1'b1, x_greater ? x_frac : y_frac};
          small_al_r    <= small_al;
          special_r     <= spec;
          special_z_r   <= spec_z;
          special_inv_r <= spec_inv;
          state         <= S_ADD;
        end
        S_ADD: begin
          sum_r  <= sub_r ? ({1'b0, big_sig_r, 3'b0} - {1'b0, small_al_r})
                          : ({1'b0, big_sig_r, 3'b0} + {1'b0, small_al_r});
          zero_r <= 1'b0;
          state  <= S_NORM;
        end
        S_NORM: begin
          if (sum_r[27]) begin
            mant_r <= {sum_r[27:2], sum_r[1] | sum_r[0]};
            exp_r  <= exp_r + 10'd1;
          end else if (sum_r == '0) begin
            zero_r <= 1'b1;
            sign_r <= 1'b0;
          end else if (exp_r <= {5'd0, lz}) begin
            zero_r <= 1'b1;
          end else begin
            mant_r <= norm_mant;
            exp_r  <= exp_r - {5'd0, lz};
          end
          state <= S_ROUND;
        end
        S_ROUND: begin
          data_valid_o               <= 1'b1;
          except_invalid_operation_o <= 1'b0;
          except_overflow_o          <= 1'b0;
          if (special_r) begin
            z_o                        <= special_z_r;
            except_invalid_operation_o <= special_inv_r;
          end else if (zero_r) begin
            z_o <= {sign_r, 31'd0};
          end else if (fin_exp >= EXP_OVF) begin
            z_o               <= POS_INF | {sign_r, 31'd0};
            except_overflow_o <= 1'b1;
          end else begin
            z_o <= {sign_r, fin_exp[7:0], fin_frac};
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_adder.sv
// Directed and random checks of fpu_adder against an exact-integer binary32 reference.
module tb_fpu_adder;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        data_ready_i = 1'b0;
  logic [6:0]  rounding_mode_i = '0;
  logic [31:0] x_i = '0;
  logic [31:0] y_i = '0;
  logic        data_valid_o;
  logic [31:0] z_o;
  logic        except_invalid_operation_o;
  logic        except_overflow_o;

  fpu_adder dut (
    .clk_i                      (clk),
    .rst_i                      (rst_i),
    .data_ready_i               (data_ready_i),
    .rounding_mode_i            (rounding_mode_i),
    .x_i                        (x_i),
    .y_i                        (y_i),
    .data_valid_o               (data_valid_o),
    .z_o                        (z_o),
    .except_invalid_operation_o (except_invalid_operation_o),
    .except_overflow_o          (except_overflow_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] z;
    logic        inv;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_valid = 0;
  int   cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference: exact sum of the two significands on a common grid, then round/truncate.
  function automatic void fp_model(input logic [31:0] x, input logic [31:0] y, input logic rne,
                                   output logic [31:0] z, output logic inv, output logic ovf);
    logic [299:0] a, b, m, rem, half, one;
    logic [24:0]  mant;
    int ex, ey, emin, p, e;
    logic s;
    logic xinf, yinf, xnan, ynan;
    z = '0; inv = 1'b0; ovf = 1'b0;
    ex = int'(x[30:23]); ey = int'(y[30:23]);
    xinf = (ex == 255) && (x[22:0] == '0); xnan = (ex == 255) && (x[22:0] != '0);
    yinf = (ey == 255) && (y[22:0] == '0); ynan = (ey == 255) && (y[22:0] != '0);
    if (xnan || ynan || (xinf && yinf)) begin z = 32'h7fffffff; inv = 1'b1; return; end
    if (xinf) begin z = x; return; end
    if (yinf) begin z = y; return; end
    if (ex == 0 && ey == 0) begin z = '0; return; end
    if (ex == 0) begin z = y; return; end
    if (ey == 0) begin z = x; return; end
    one  = 300'd1;
    emin = (ex < ey) ? ex : ey;
    a = 300'({1'b1, x[22:0]}) << (ex - emin);
    b = 300'({1'b1, y[22:0]}) << (ey - emin);
    if (x[31] == y[31]) begin m = a + b; s = x[31]; end
    else if (a >= b) begin m = a - b; s = x[31]; end
    else begin m = b - a; s = y[31]; end
    p = -1;
    for (int i = 0; i < 300; i++) if (m[i]) p = i;
    if (p < 0) begin z = '0; return; end
    e = emin + p - 23;
    if (e <= 0) begin z = {s, 31'd0}; return; end
    if (p >= 23) begin
      mant = 25'(m >> (p - 23));
      rem  = m & ((one << (p - 23)) - one);
    end else begin
      mant = 25'(m << (23 - p));
      rem  = '0;
    end
    if (rne && p >= 24) begin
      half = one << (p - 24);
      if (rem > half || (rem == half && mant[0])) mant = mant + 25'd1;
    end
    if (mant[24]) begin mant = mant >> 1; e++; end
    if (e >= 255) begin z = {s, 8'hff, 23'd0}; ovf = 1'b1; end
    else z = {s, 8'(e), mant[22:0]};
  endfunction

  always @(negedge clk) begin
    if (data_valid_o) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got valid=1 at cycle %0d, expected no result pending", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("latency", 32'(cyc), 32'(e.cyc));
        check("model_z", z_o, e.z);
        check("model_invalid", 32'(except_invalid_operation_o), 32'(e.inv));
        check("model_overflow", 32'(except_overflow_o), 32'(e.ovf));
      end
    end
  end

  task automatic wait_result(input int start);
    for (int i = 0; i < 20 && n_valid == start; i++) @(posedge clk);
    #1;
    if (n_valid == start) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: got no valid within 20 cycles, expected one");
    end
  endtask

  task automatic run_op(input logic [31:0] xa, input logic [31:0] ya, input logic [6:0] rm,
                        input int busy_cycles);
    exp_t e;
    int   start;
    @(negedge clk);
    fp_model(xa, ya, rm[0], e.z, e.inv, e.ovf);
    e.cyc = cyc + 5;
    exp_q.push_back(e);
    start = n_valid;
    x_i = xa; y_i = ya; rounding_mode_i = rm; data_ready_i = 1'b1;
    for (int i = 0; i < busy_cycles; i++) begin
      @(negedge clk);
      x_i = 32'h3f800000; y_i = 32'h3f800000; rounding_mode_i = 7'h01;
    end
    @(negedge clk);
    data_ready_i = 1'b0;
    wait_result(start);
  endtask

  task automatic dir(input string name, input logic [31:0] xa, input logic [31:0] ya,
                     input logic [6:0] rm, input logic [31:0] z, input logic inv, input logic ovf);
    run_op(xa, ya, rm, 0);
    check({name, "_z"}, z_o, z);
    check({name, "_inv"}, 32'(except_invalid_operation_o), 32'(inv));
    check({name, "_ovf"}, 32'(except_overflow_o), 32'(ovf));
  endtask

  initial begin
    logic [31:0] xr, yr;
    logic [7:0]  ye;
    logic [6:0]  rm;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_z", z_o, 32'h0);
    check("reset_valid", 32'(data_valid_o), 32'h0);
    check("reset_inv", 32'(except_invalid_operation_o), 32'h0);
    check("reset_ovf", 32'(except_overflow_o), 32'h0);
    rst_i = 1'b1;

    dir("add_basic",   32'h3fc00000, 32'h4500001a, 7'h00, 32'h4500181a, 1'b0, 1'b0);
    dir("norm_left",   32'h3f000000, 32'hbee00000, 7'h00, 32'h3d800000, 1'b0, 1'b0);
    dir("trunc",       32'h4479ff5c, 32'h3c23d70a, 7'h00, 32'h4479ffff, 1'b0, 1'b0);
    dir("sub_neg",     32'h431617a8, 32'hc3480000, 7'h00, 32'hc247a160, 1'b0, 1'b0);
    dir("zero_y",      32'h484c3381, 32'h00000000, 7'h00, 32'h484c3381, 1'b0, 1'b0);
    dir("negzero_y",   32'h4479ff5c, 32'h80000000, 7'h00, 32'h4479ff5c, 1'b0, 1'b0);
    dir("inf_y",       32'h4479ff5c, 32'hff800000, 7'h00, 32'hff800000, 1'b0, 1'b0);
    dir("inf_x",       32'h7f800000, 32'hc21f36ae, 7'h00, 32'h7f800000, 1'b0, 1'b0);
    dir("inf_inf",     32'h7f800000, 32'h7f800000, 7'h00, 32'h7fffffff, 1'b1, 1'b0);
    dir("inf_ninf",    32'h7f800000, 32'hff800000, 7'h00, 32'h7fffffff, 1'b1, 1'b0);
    dir("nan_y",       32'h3db8d4fe, 32'hffffffff, 7'h00, 32'h7fffffff, 1'b1, 1'b0);
    dir("ovf_a",       32'h7f61b1e6, 32'h7e348e52, 7'h00, 32'h7f800000, 1'b0, 1'b1);
    dir("ovf_b",       32'h7f7fffff, 32'h7cf0bdc2, 7'h00, 32'h7f800000, 1'b0, 1'b1);
    dir("rne_carry",   32'h4479ff5c, 32'h3c23d70a, 7'h01, 32'h447a0000, 1'b0, 1'b0);
    dir("rne_multi",   32'h4479ff5c, 32'h3c23d70a, 7'h03, 32'h447a0000, 1'b0, 1'b0);
    dir("trunc_bit6",  32'h4479ff5c, 32'h3c23d70a, 7'h40, 32'h4479ffff, 1'b0, 1'b0);
    dir("tie_even",    32'h3f800000, 32'h33800000, 7'h01, 32'h3f800000, 1'b0, 1'b0);
    dir("tie_odd",     32'h3f800001, 32'h33800000, 7'h01, 32'h3f800002, 1'b0, 1'b0);
    dir("tie_trunc",   32'h3f800001, 32'h33800000, 7'h00, 32'h3f800001, 1'b0, 1'b0);
    dir("cancel",      32'h3f800000, 32'hbf800000, 7'h00, 32'h00000000, 1'b0, 1'b0);
    dir("both_zero",   32'h80000000, 32'h80000000, 7'h00, 32'h00000000, 1'b0, 1'b0);
    dir("underflow",   32'h80800001, 32'h00800000, 7'h00, 32'h80000000, 1'b0, 1'b0);
    dir("double",      32'h3f800000, 32'h3f800000, 7'h01, 32'h40000000, 1'b0, 1'b0);

    // Outputs hold after the pulse; a request held high while busy must not start a second op.
    repeat (3) @(negedge clk);
    check("hold_z", z_o, 32'h40000000);
    check("hold_valid", 32'(data_valid_o), 32'h0);
    run_op(32'h3fc00000, 32'h4500001a, 7'h00, 2);
    check("busy_z", z_o, 32'h4500181a);
    repeat (8) @(negedge clk);
    check("busy_single", 32'(exp_q.size()), 32'h0);

    // Reset in the middle of an operation aborts it.
    @(negedge clk);
    x_i = 32'h3f800000; y_i = 32'h3f800000; data_ready_i = 1'b1;
    @(negedge clk);
    data_ready_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_z", z_o, 32'h0);
    check("abort_inv", 32'(except_invalid_operation_o), 32'h0);
    check("abort_ovf", 32'(except_overflow_o), 32'h0);
    dir("after_abort", 32'h3f000000, 32'hbee00000, 7'h00, 32'h3d800000, 1'b0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      xr = $urandom;
      if (n % 3 != 0) begin
        ye = xr[30:23] ^ 8'($urandom_range(0, 7));
        yr = {1'($urandom_range(0, 1)), ye, 23'($urandom)};
      end else begin
        yr = $urandom;
      end
      case ($urandom_range(0, 3))
        0: rm = 7'h00;
        1: rm = 7'h01;
        2: rm = 7'h7f;
        default: rm = 7'h40;
      endcase
      run_op(xr, yr, rm, 0);
    end

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
